// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared constants for the 16-bit datapath register file: data and address
// widths, register count and the index of the hardwired zero register.
// The address width helper lets the top confirm that NREGS fills its address space.
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;

  // Index of the register that always reads as zero and has no storage.
  localparam logic [2:0] ZERO_REG = 3'd0;

  // Number of address bits needed to reach every entry of an n-entry file.
  function automatic int addr_bits_for(input int n);
    int bits;
    bits = 0;
    while ((32'sd1 <<< bits) < n) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage : reg_file_pkg

// File: rtl/reg_file_read_mux.sv
// -----------------------------------------------------------------------------
// reg_file_read_mux
// NREGS:1 read multiplexer for one register file read port.
// The mux contains no state. It has an AND-OR select tree, and address
// ZERO_REG always returns zero.
//
// Ports:
//   regs   in   (NREGS-1)*DATA_W  R1..R7 packed, R1 in the lowest slice
//   addr   in   ADDR_W            read address
//   rdata  out  DATA_W            selected register value (0 for ZERO_REG)
// -----------------------------------------------------------------------------
module reg_file_read_mux
  import reg_file_pkg::*;
#(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W,
  parameter int NREGS  = reg_file_pkg::NREGS
) (
  input  logic [(NREGS-1)*DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]           addr,
  output logic [DATA_W-1:0]           rdata
);

  logic [DATA_W-1:0] or_tree_s;

  // AND-OR select of R1..R7. At most one term is non-zero for any address.
  always_comb begin
    or_tree_s = {DATA_W{1'b0}};
    for (int i = 1; i < NREGS; i++) begin
      or_tree_s = or_tree_s
                | ({DATA_W{addr == ADDR_W'(i)}} & regs[(i-1)*DATA_W +: DATA_W]);
    end
  end

  // The zero-register override is explicit. It does not depend on the
  // select tree producing zero when no term matches.
  always_comb begin
    rdata = {DATA_W{1'b0}};
    if (addr == ADDR_W'(ZERO_REG)) begin
      rdata = {DATA_W{1'b0}};
    end else begin
      rdata = or_tree_s;
    end
  end

endmodule : reg_file_read_mux

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 8 x 16-bit register file placed between decode and the ALU. It has two
// combinational read ports and one write port that updates on the rising
// clock edge. R0 has no storage and always reads zero. Writes to R0 are dropped.
// There is no write-to-read bypass. A read of the register being written shows
// the old value until the edge.
//
// Ports (positional order):
//   rdata1  out  DATA_W  R[raddr1]
//   rdata2  out  DATA_W  R[raddr2]
//   clock   in   1       rising-edge clock
//   wdata   in   DATA_W  write data
//   waddr   in   ADDR_W  write address
//   raddr1  in   ADDR_W  read address, port 1
//   raddr2  in   ADDR_W  read address, port 2
//   write   in   1       write enable, active high
//   reset   in   1       asynchronous active-high clear of R1..R7
// -----------------------------------------------------------------------------
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W,
  parameter int NREGS  = reg_file_pkg::NREGS
) (
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              clock,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic              write,
  input  logic              reset
);

  // The address space must map exactly onto the register array.
  if ((NREGS != (32'sd1 <<< ADDR_W)) || (addr_bits_for(NREGS) != ADDR_W)) begin : g_bad_cfg
    $error("reg_file: NREGS must equal 2**ADDR_W");
  end

  // Storage exists only for R1..NREGS-1.
  logic [DATA_W-1:0]           regs_r [1:NREGS-1];
  logic [NREGS-1:1]            wen_s;
  logic [(NREGS-1)*DATA_W-1:0] regs_flat_s;

  // One-hot write decode. An address of ZERO_REG produces no enable.
  always_comb begin
    wen_s = '0;
    for (int i = 1; i < NREGS; i++) begin
      wen_s[i] = write & (waddr == ADDR_W'(i));
    end
  end

  // Register array. Reset is level-sensitive, so it also overrides a write
  // that arrives on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wen_s[i]) begin
          regs_r[i] <= wdata;
        end
      end
    end
  end

  // Pack R1..R7 into one vector that both read muxes share.
  always_comb begin
    regs_flat_s = '0;
    for (int i = 1; i < NREGS; i++) begin
      regs_flat_s[(i-1)*DATA_W +: DATA_W] = regs_r[i];
    end
  end

  reg_file_read_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_read_mux1 (
    .regs  (regs_flat_s),
    .addr  (raddr1),
    .rdata (rdata1)
  );

  reg_file_read_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_read_mux2 (
    .regs  (regs_flat_s),
    .addr  (raddr2),
    .rdata (rdata2)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
// Directed self-checking bench for reg_file. The clock period is 2 time units.
// Inputs change on the falling edge. Combinational reads are sampled a short
// settle time after each input change or rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_file;

  logic [15:0] rdata1;
  logic [15:0] rdata2;
  logic        clock;
  logic [15:0] wdata;
  logic [2:0]  waddr;
  logic [2:0]  raddr1;
  logic [2:0]  raddr2;
  logic        write;
  logic        reset;

  int errors;
  int checks;

  // Hand-computed sweep contents: R[i] = i*1000 + i, and R0 reads 0.
  logic [15:0] sweep_exp [0:7];

  reg_file dut (
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .clock  (clock),
    .wdata  (wdata),
    .waddr  (waddr),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .write  (write),
    .reset  (reset)
  );

  initial clock = 1'b0;
  always #1 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait for the next rising edge and let combinational reads settle.
  task automatic edge_settle();
    @(posedge clock);
    #0.2;
  endtask

  // Move to the falling edge, where the bench drives new inputs.
  task automatic to_negedge();
    @(negedge clock);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    sweep_exp[0] = 16'd0;
    sweep_exp[1] = 16'd1001;
    sweep_exp[2] = 16'd2002;
    sweep_exp[3] = 16'd3003;
    sweep_exp[4] = 16'd4004;
    sweep_exp[5] = 16'd5005;
    sweep_exp[6] = 16'd6006;
    sweep_exp[7] = 16'd7007;

    // Reset then idle
    reset  = 1'b1;
    write  = 1'b0;
    raddr1 = 3'd0;
    raddr2 = 3'd1;
    wdata  = 16'd9;
    waddr  = 3'd1;
    #3.2;
    check("reset_rd1", rdata1, 16'd0);
    check("reset_rd2", rdata2, 16'd0);
    to_negedge();
    reset = 1'b0;
    edge_settle();
    edge_settle();
    check("idle_rd1", rdata1, 16'd0);
    check("idle_rd2_r1", rdata2, 16'd0);

    // Basic write of R1
    to_negedge();
    write = 1'b1;
    #0.2;
    check("prewrite_r1", rdata2, 16'd0);
    edge_settle();
    check("write_r1", rdata2, 16'd9);
    check("write_r1_rd1_zero", rdata1, 16'd0);
    to_negedge();
    write = 1'b0;
    edge_settle();
    check("hold_r1", rdata2, 16'd9);

    // Second register and read-before-edge
    to_negedge();
    raddr1 = 3'd6;
    waddr  = 3'd6;
    wdata  = 16'd7;
    #0.2;
    check("r6_before", rdata1, 16'd0);
    to_negedge();
    write = 1'b1;
    #0.2;
    check("r6_before_edge", rdata1, 16'd0);
    edge_settle();
    check("r6_after", rdata1, 16'd7);
    check("r1_still", rdata2, 16'd9);
    to_negedge();
    write = 1'b0;

    // A write to the zero register is discarded
    raddr2 = 3'd0;
    waddr  = 3'd0;
    wdata  = 16'd7;
    #0.2;
    check("r0_before", rdata2, 16'd0);
    to_negedge();
    write = 1'b1;
    edge_settle();
    check("r0_after", rdata2, 16'd0);
    to_negedge();
    write  = 1'b0;
    raddr2 = 3'd1;
    #0.2;
    check("r6_untouched", rdata1, 16'd7);
    check("r1_untouched", rdata2, 16'd9);

    // A write-enable pulse that lies entirely between edges has no effect
    waddr = 3'd1;
    wdata = 16'd55;
    #0.3;
    write = 1'b1;
    #0.3;
    write = 1'b0;
    edge_settle();
    check("glitch_r1", rdata2, 16'd9);

    // Async reset mid-operation
    to_negedge();
    #0.3;
    reset = 1'b1;
    #0.2;
    check("areset_r6", rdata1, 16'd0);
    check("areset_r1", rdata2, 16'd0);
    write = 1'b1;
    waddr = 3'd1;
    wdata = 16'd5;
    edge_settle();
    check("reset_wr_r1", rdata2, 16'd0);
    to_negedge();
    waddr = 3'd6;
    edge_settle();
    check("reset_wr_r6", rdata1, 16'd0);
    to_negedge();
    write = 1'b0;
    reset = 1'b0;
    edge_settle();
    check("post_reset_r1", rdata2, 16'd0);

    // Sweep: write all of R1..R7, then read every address pair
    for (int i = 1; i < 8; i++) begin
      to_negedge();
      write = 1'b1;
      waddr = 3'(i);
      wdata = sweep_exp[i];
    end
    to_negedge();
    write = 1'b0;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        raddr1 = 3'(a);
        raddr2 = 3'(b);
        #0.1;
        check($sformatf("sweep_rd1_a%0d", a), rdata1, sweep_exp[a]);
        check($sformatf("sweep_rd2_a%0d", b), rdata2, sweep_exp[b]);
      end
    end

    // write=0 leaves the register unchanged whatever waddr and wdata are
    to_negedge();
    raddr1 = 3'd3;
    waddr  = 3'd3;
    wdata  = 16'hFFFF;
    write  = 1'b0;
    edge_settle();
    check("nowrite_r3", rdata1, 16'd3003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg_file
